// File: rtl/l0_maxpool_2x2.sv
// 2x2 stride-2 max-pool of the 64x64 layer-0 result into the 32x32 layer-1 memory.
// Optional build macro POOL_CEIL_EN: round each pooled value up to an integer before write-back.
module l0_maxpool_2x2 #(
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned IMG_W      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  crd,
  output logic [ADDR_WIDTH-1:0] caddr_rd,
  input  logic [DATA_WIDTH-1:0] cdata_rd,
  output logic                  cwr,
  output logic [ADDR_WIDTH-1:0] caddr_wr,
  output logic [DATA_WIDTH-1:0] cdata_wr,
  output logic [2:0]            csel
);

  localparam int unsigned OUT_W = IMG_W / 2;
  localparam int unsigned CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT_W - 1);
  localparam logic [2:0] CSEL_IDLE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_LAST, S_WR, S_DONE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_orow, r_ocol, w_orow_nxt, w_ocol_nxt;
  logic [DATA_WIDTH-1:0] r_max, w_max_nxt, w_cmp;
  logic [ADDR_WIDTH-1:0] w_base;

  logic                  r_busy, r_done, r_crd, r_cwr;
  logic [ADDR_WIDTH-1:0] r_caddr_rd, r_caddr_wr;
  logic [DATA_WIDTH-1:0] r_cdata_wr;
  logic [2:0]            r_csel;

  logic                  w_busy, w_done, w_crd, w_cwr;
  logic [ADDR_WIDTH-1:0] w_caddr_rd, w_caddr_wr;
  logic [DATA_WIDTH-1:0] w_cdata_wr;
  logic [2:0]            w_csel;

`ifdef POOL_CEIL_EN
  localparam int unsigned FRAC_W = 16;
  localparam int unsigned INT_W  = DATA_WIDTH - FRAC_W;
`endif

  // Write-back value: ceiling to an integer with saturation, or pass-through.
  function automatic logic [DATA_WIDTH-1:0] f_pool(input logic [DATA_WIDTH-1:0] v);
`ifdef POOL_CEIL_EN
    logic [DATA_WIDTH-1:0] res;
    if (v[FRAC_W-1:0] == '0) begin
      res = v;
    end else if (&v[DATA_WIDTH-1:FRAC_W]) begin
      res = '1;
    end else begin
      res = {INT_W'(v[DATA_WIDTH-1:FRAC_W] + INT_W'(1)), FRAC_W'(0)};
    end
    return res;
`else
    return v;
`endif
  endfunction

  // Next state, counters, running max and registered-output next values.
  always_comb begin
    w_state_nxt = r_state;
    w_orow_nxt  = r_orow;
    w_ocol_nxt  = r_ocol;
    w_max_nxt   = r_max;
    w_cmp       = (cdata_rd > r_max) ? cdata_rd : r_max;
    w_cdata_wr  = r_cdata_wr;
    w_caddr_rd  = r_caddr_rd;
    w_caddr_wr  = r_caddr_wr;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_crd       = 1'b0;
    w_cwr       = 1'b0;
    w_csel      = CSEL_IDLE;
    w_base      = '0;

    case (r_state)
      S_IDLE: begin
        w_orow_nxt = '0;
        w_ocol_nxt = '0;
        if (start) w_state_nxt = S_RD0;
      end
      S_RD0: w_state_nxt = S_RD1;
      S_RD1: begin
        w_max_nxt   = cdata_rd;
        w_state_nxt = S_RD2;
      end
      S_RD2: begin
        w_max_nxt   = w_cmp;
        w_state_nxt = S_RD3;
      end
      S_RD3: begin
        w_max_nxt   = w_cmp;
        w_state_nxt = S_LAST;
      end
      S_LAST: begin
        w_max_nxt   = w_cmp;
        w_cdata_wr  = f_pool(w_cmp);
        w_state_nxt = S_WR;
      end
      S_WR: begin
        if ((r_ocol == LAST_IDX) && (r_orow == LAST_IDX)) begin
          w_state_nxt = S_DONE;
        end else begin
          if (r_ocol == LAST_IDX) begin
            w_ocol_nxt = '0;
            w_orow_nxt = r_orow + CNT_W'(1);
          end else begin
            w_ocol_nxt = r_ocol + CNT_W'(1);
          end
          w_state_nxt = S_RD0;
        end
      end
      S_DONE: begin
        w_orow_nxt  = '0;
        w_ocol_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are decoded from the state being entered so they register alongside it.
    w_base = ADDR_WIDTH'(32'(w_orow_nxt) * (32'd2 * IMG_W) + 32'(w_ocol_nxt) * 32'd2);
    case (w_state_nxt)
      S_RD0: w_caddr_rd = w_base;
      S_RD1: w_caddr_rd = w_base + ADDR_WIDTH'(1);
      S_RD2: w_caddr_rd = w_base + ADDR_WIDTH'(IMG_W);
      S_RD3: w_caddr_rd = w_base + ADDR_WIDTH'(IMG_W + 1);
      S_WR:  w_caddr_wr = ADDR_WIDTH'(32'(w_orow_nxt) * OUT_W + 32'(w_ocol_nxt));
      default: ;
    endcase

    case (w_state_nxt)
      S_RD0, S_RD1, S_RD2, S_RD3: begin
        w_busy = 1'b1;
        w_crd  = 1'b1;
        w_csel = CSEL_L0;
      end
      S_LAST: w_busy = 1'b1;
      S_WR: begin
        w_busy = 1'b1;
        w_cwr  = 1'b1;
        w_csel = CSEL_L1;
      end
      S_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_orow     <= '0;
      r_ocol     <= '0;
      r_max      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_crd      <= 1'b0;
      r_cwr      <= 1'b0;
      r_caddr_rd <= '0;
      r_caddr_wr <= '0;
      r_cdata_wr <= '0;
      r_csel     <= CSEL_IDLE;
    end else begin
      r_state    <= w_state_nxt;
      r_orow     <= w_orow_nxt;
      r_ocol     <= w_ocol_nxt;
      r_max      <= w_max_nxt;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_crd      <= w_crd;
      r_cwr      <= w_cwr;
      r_caddr_rd <= w_caddr_rd;
      r_caddr_wr <= w_caddr_wr;
      r_cdata_wr <= w_cdata_wr;
      r_csel     <= w_csel;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign crd      = r_crd;
  assign cwr      = r_cwr;
  assign caddr_rd = r_caddr_rd;
  assign caddr_wr = r_caddr_wr;
  assign cdata_wr = r_cdata_wr;
  assign csel     = r_csel;

endmodule

// File: tb/tb_l0_maxpool_2x2.sv
// Directed bench for l0_maxpool_2x2 with behavioural L0/L1 memories.
module tb_l0_maxpool_2x2;

  localparam int unsigned DW = 20;
  localparam int unsigned AW = 12;
  localparam int unsigned LOGN = 16384;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done, crd, cwr;
  logic [AW-1:0] caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd = '0;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] l0 [4096];
  logic [DW-1:0] l1 [1024];
  logic [AW-1:0] rd_log  [LOGN];
  logic [AW-1:0] wr_alog [LOGN];
  logic [DW-1:0] wr_dlog [LOGN];
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  l0_maxpool_2x2 dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

  always #5 clk = ~clk;

  // Memory responder and access logger.
  always @(posedge clk) begin
    if (crd && csel == 3'b001) begin
      cdata_rd <= l0[caddr_rd];
      rd_log[rd_cnt % LOGN] <= caddr_rd;
      rd_cnt <= rd_cnt + 1;
    end
    if (cwr && csel == 3'b011) begin
      l1[caddr_wr[9:0]] <= cdata_wr;
      wr_alog[wr_cnt % LOGN] <= caddr_wr;
      wr_dlog[wr_cnt % LOGN] <= cdata_wr;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_writes(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (wr_cnt >= target) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int r0, w0;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({busy, done, crd, cwr, csel} !== 7'b0) begin
      mismatched++;
      $display("FAIL rst_ctrl: got %b required 0000000", {busy, done, crd, cwr, csel});
    end
    compared++;
    if ({caddr_rd, caddr_wr, cdata_wr} !== '0) begin
      mismatched++;
      $display("FAIL rst_regs: got rd=%h wr=%h data=%h required all 0", caddr_rd, caddr_wr, cdata_wr);
    end
    reset = 1'b1;
    r0 = rd_cnt;
    w0 = wr_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      compared++;
      if ({busy, done, crd, cwr, csel} !== 7'b0) begin
        mismatched++;
        $display("FAIL idle_ctrl cyc %0d: got %b required 0000000", i, {busy, done, crd, cwr, csel});
      end
    end
    compared++;
    if (rd_cnt != r0 || wr_cnt != w0) begin
      mismatched++;
      $display("FAIL idle_access: got %0d reads %0d writes required 0", rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_single_window;
    logic [AW-1:0] ea [4];
    ea[0] = 12'd0; ea[1] = 12'd1; ea[2] = 12'd64; ea[3] = 12'd65;
    l0[0]  = 20'h01000;
    l0[1]  = 20'h03000;
    l0[64] = 20'h02000;
    l0[65] = 20'h00500;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      compared++;
      if (crd !== 1'b1 || csel !== 3'b001 || caddr_rd !== ea[k] || busy !== 1'b1 || cwr !== 1'b0) begin
        mismatched++;
        $display("FAIL win_rd%0d: got crd=%b csel=%b addr=%0d busy=%b cwr=%b required 1 001 %0d 1 0",
                 k, crd, csel, caddr_rd, busy, cwr, ea[k]);
      end
    end
    @(negedge clk);
    compared++;
    if (crd !== 1'b0 || cwr !== 1'b0 || csel !== 3'b000 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL win_last: got crd=%b cwr=%b csel=%b busy=%b required 0 0 000 1", crd, cwr, csel, busy);
    end
    @(negedge clk);
    compared++;
    if (cwr !== 1'b1 || csel !== 3'b011 || caddr_wr !== 12'd0 || cdata_wr !== 20'h03000) begin
      mismatched++;
      $display("FAIL win_wr: got cwr=%b csel=%b addr=%0d data=%h required 1 011 0 03000",
               cwr, csel, caddr_wr, cdata_wr);
    end
    @(negedge clk);
    compared++;
    if (crd !== 1'b1 || caddr_rd !== 12'd2 || cwr !== 1'b0) begin
      mismatched++;
      $display("FAIL win_next: got crd=%b addr=%0d cwr=%b required 1 2 0", crd, caddr_rd, cwr);
    end
  endtask

  task automatic test_mid_reset;
    int r0, w0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    compared++;
    if ({busy, done, crd, cwr, csel} !== 7'b0) begin
      mismatched++;
      $display("FAIL abort_now: got %b required 0000000", {busy, done, crd, cwr, csel});
    end
    r0 = rd_cnt;
    w0 = wr_cnt;
    repeat (3) @(negedge clk);
    compared++;
    if (rd_cnt != r0 || wr_cnt != w0 || crd !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_hold: got %0d reads %0d writes crd=%b required 0 0 0", rd_cnt - r0, wr_cnt - w0, crd);
    end
    reset = 1'b1;
    w0 = wr_cnt;
    pulse_start();
    compared++;
    if (crd !== 1'b1 || caddr_rd !== 12'd0) begin
      mismatched++;
      $display("FAIL restart_rd: got crd=%b addr=%0d required 1 0", crd, caddr_rd);
    end
    wait_writes(w0 + 1, 20);
    compared++;
    if (wr_cnt < w0 + 1) begin
      mismatched++;
      $display("FAIL restart_timeout: got %0d writes required 1", wr_cnt - w0);
    end else if (wr_alog[w0 % LOGN] !== 12'd0 || wr_dlog[w0 % LOGN] !== 20'h03000) begin
      mismatched++;
      $display("FAIL restart_wr: got addr=%0d data=%h required 0 03000",
               wr_alog[w0 % LOGN], wr_dlog[w0 % LOGN]);
    end
    do_reset();
  endtask

  task automatic test_ties;
    int w0;
    int off [4];
    off[0] = 0; off[1] = 1; off[2] = 64; off[3] = 65;
    for (int i = 0; i < 8; i++) begin
      l0[i]      = 20'h0ABCD;
      l0[64 + i] = 20'h0ABCD;
    end
    for (int k = 0; k < 4; k++) l0[2 * k + off[k]] = 20'h0ABCE;
    w0 = wr_cnt;
    pulse_start();
    wait_writes(w0 + 4, 60);
    compared++;
    if (wr_cnt < w0 + 4) begin
      mismatched++;
      $display("FAIL ties_timeout: got %0d writes required 4", wr_cnt - w0);
    end
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (wr_alog[(w0 + k) % LOGN] !== AW'(k) || wr_dlog[(w0 + k) % LOGN] !== 20'h0ABCE) begin
        mismatched++;
        $display("FAIL ties_pos%0d: got addr=%0d data=%h required %0d 0ABCE",
                 k, wr_alog[(w0 + k) % LOGN], wr_dlog[(w0 + k) % LOGN], k);
      end
    end
    do_reset();
  endtask

  task automatic test_ceil;
    int w0;
    logic [DW-1:0] vmax [5];
    logic [DW-1:0] vexp [5];
    vmax[0] = 20'h21000; vmax[1] = 20'h40000; vmax[2] = 20'hF0001;
    vmax[3] = 20'h0FFFF; vmax[4] = 20'h00000;
`ifdef POOL_CEIL_EN
    vexp[0] = 20'h30000; vexp[1] = 20'h40000; vexp[2] = 20'hFFFFF;
    vexp[3] = 20'h10000; vexp[4] = 20'h00000;
`else
    vexp[0] = 20'h21000; vexp[1] = 20'h40000; vexp[2] = 20'hF0001;
    vexp[3] = 20'h0FFFF; vexp[4] = 20'h00000;
`endif
    for (int c = 0; c < 5; c++) begin
      l0[2 * c]      = (c == 4) ? 20'h0 : 20'h00001;
      l0[2 * c + 1]  = (c == 4) ? 20'h0 : 20'h00001;
      l0[64 + 2 * c] = (c == 4) ? 20'h0 : 20'h00001;
      l0[65 + 2 * c] = vmax[c];
    end
    w0 = wr_cnt;
    pulse_start();
    wait_writes(w0 + 5, 60);
    compared++;
    if (wr_cnt < w0 + 5) begin
      mismatched++;
      $display("FAIL ceil_timeout: got %0d writes required 5", wr_cnt - w0);
    end
    for (int c = 0; c < 5; c++) begin
      compared++;
      if (wr_dlog[(w0 + c) % LOGN] !== vexp[c]) begin
        mismatched++;
        $display("FAIL ceil_%0d: got %h required %h", c, wr_dlog[(w0 + c) % LOGN], vexp[c]);
      end
    end
    do_reset();
  endtask

  task automatic test_full_image;
    int r0, w0, d0, n;
    logic prev_busy, busy_at_done;
    logic [DW-1:0] e;
    for (int a = 0; a < 4096; a++) l0[a] = DW'(a);
    r0 = rd_cnt;
    w0 = wr_cnt;
    d0 = done_cnt;
    n = -1;
    prev_busy = 1'b0;
    busy_at_done = 1'bx;
    pulse_start();
    for (int k = 0; k < 7000; k++) begin
      if (done === 1'b1) begin
        n = k;
        busy_at_done = busy;
        break;
      end
      prev_busy = busy;
      start = (k == 100) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    compared++;
    if (n != 6144) begin
      mismatched++;
      $display("FAIL full_latency: got done at cycle %0d required 6144", n);
    end
    compared++;
    if (busy_at_done !== 1'b0 || prev_busy !== 1'b1) begin
      mismatched++;
      $display("FAIL full_busy_edge: got busy=%b before=%b required 0 1", busy_at_done, prev_busy);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (done_cnt - d0 != 1 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL full_done: got %0d pulses busy=%b done=%b required 1 0 0", done_cnt - d0, busy, done);
    end
    compared++;
    if (wr_cnt - w0 != 1024 || rd_cnt - r0 != 4096) begin
      mismatched++;
      $display("FAIL full_counts: got %0d writes %0d reads required 1024 4096", wr_cnt - w0, rd_cnt - r0);
    end
    compared++;
    if (rd_log[r0 % LOGN] !== 12'd0 || rd_log[(r0 + 1) % LOGN] !== 12'd1 ||
        rd_log[(r0 + 2) % LOGN] !== 12'd64 || rd_log[(r0 + 3) % LOGN] !== 12'd65) begin
      mismatched++;
      $display("FAIL full_first_reads: got %0d %0d %0d %0d required 0 1 64 65", rd_log[r0 % LOGN],
               rd_log[(r0 + 1) % LOGN], rd_log[(r0 + 2) % LOGN], rd_log[(r0 + 3) % LOGN]);
    end
    compared++;
    if (rd_log[(r0 + 128) % LOGN] !== 12'd128) begin
      mismatched++;
      $display("FAIL wrap_read: got %0d required 128", rd_log[(r0 + 128) % LOGN]);
    end
    compared++;
    if (wr_alog[(w0 + 31) % LOGN] !== 12'd31 || wr_alog[(w0 + 32) % LOGN] !== 12'd32) begin
      mismatched++;
      $display("FAIL wrap_write: got %0d %0d required 31 32",
               wr_alog[(w0 + 31) % LOGN], wr_alog[(w0 + 32) % LOGN]);
    end
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        e = DW'((2 * r + 1) * 64 + 2 * c + 1);
        compared++;
        if (l1[r * 32 + c] !== e) begin
          mismatched++;
          $display("FAIL full_l1[%0d]: got %h required %h", r * 32 + c, l1[r * 32 + c], e);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    for (int a = 0; a < 4096; a++) l0[a] = '0;
    for (int a = 0; a < 1024; a++) l1[a] = '0;
    test_reset();
    test_single_window();
    test_mid_reset();
    test_ties();
    test_ceil();
    test_full_image();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
